mc_control_fsm: RTL and testbench

Multi-cycle MIPS control unit with memory wait-state support. It sits between the instruction register/zero flag of the datapath and the datapath mux selects, write enables and memory strobes. It extends the fixed-latency multi-cycle controller with several additions: variable-latency memory via a `mem_ready` handshake, a bus watchdog, `bne`/`jal`/`jr`/`slti`, illegal-opcode trapping, and a parametrised ALU-op width.

---
 rtl/mc_pkg.sv | 60 ++++++
 rtl/mc_alu_decoder.sv | 36 +++
 rtl/mc_control_fsm.sv | 229 ++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP,
    S_JAL, S_JR, S_ILLEGAL, S_FAULT
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD, ALU_SUB, ALU_SLT, ALU_FUNC
  } alu_class_e;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALUOP_AND = 3'b000;
  localparam logic [2:0] ALUOP_OR  = 3'b001;
  localparam logic [2:0] ALUOP_ADD = 3'b010;
  localparam logic [2:0] ALUOP_SUB = 3'b110;
  localparam logic [2:0] ALUOP_SLT = 3'b111;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MDR = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_BR  = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_REG    = 2'b11;

  // States that wait on the mem_ready handshake and are guarded by the watchdog.
  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Maps the controller's ALU class and the R-type func field to an ALU op code.
module mc_alu_decoder
  import mc_pkg::*;
#(
  parameter int OP_W = 3
) (
  input  alu_class_e        alu_class,
  input  logic [5:0]        func,
  output logic [OP_W-1:0]   operation
);

  logic [2:0] op3;

  always_comb begin
    op3 = ALUOP_ADD;
    case (alu_class)
      ALU_ADD: op3 = ALUOP_ADD;
      ALU_SUB: op3 = ALUOP_SUB;
      ALU_SLT: op3 = ALUOP_SLT;
      ALU_FUNC: begin
        case (func)
          FN_ADD:  op3 = ALUOP_ADD;
          FN_SUB:  op3 = ALUOP_SUB;
          FN_AND:  op3 = ALUOP_AND;
          FN_OR:   op3 = ALUOP_OR;
          FN_SLT:  op3 = ALUOP_SLT;
          default: op3 = ALUOP_ADD;
        endcase
      end
      default: op3 = ALUOP_ADD;
    endcase
  end

  assign operation = OP_W'(op3);

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control FSM with mem_ready wait states, a bus watchdog,
// and illegal-instruction trapping.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int OP_W     = 3,
  parameter int WAIT_MAX = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      opcode,
  input  logic [5:0]      func,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            mem_read,
  output logic            mem_write,
  output logic            IorD,
  output logic            ir_write,
  output logic [1:0]      reg_dst,
  output logic [1:0]      mem_to_reg,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [OP_W-1:0] operation,
  output logic [1:0]      pc_src,
  output logic            pc_load,
  output logic            illegal,
  output logic            bus_error
);

  localparam int CNT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

  state_e     state_q, state_d;
  logic       is_bne_q, is_bne_d;
  logic       wd_expire;
  alu_class_e alu_class;
  logic       op_en;
  logic       pc_write, pc_write_cond;
  logic [OP_W-1:0] dec_op;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      is_bne_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_bne_q <= is_bne_d;
    end
  end

  // Watchdog: counts consecutive not-ready cycles within one memory state.
  generate
    if (WAIT_MAX > 0) begin : g_wd
      logic [CNT_W-1:0] wcnt_q, wcnt_d;

      always_comb begin
        wcnt_d = wcnt_q;
        if (state_d != state_q)
          wcnt_d = '0;
        else if (is_mem_state(state_q) && !mem_ready)
          wcnt_d = wcnt_q + CNT_W'(1);
      end

      always_ff @(posedge clk) begin
        if (rst) wcnt_q <= '0;
        else     wcnt_q <= wcnt_d;
      end

      assign wd_expire = is_mem_state(state_q) && !mem_ready &&
                         (wcnt_q == CNT_W'(WAIT_MAX));
    end else begin : g_no_wd
      assign wd_expire = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    is_bne_d = is_bne_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)      state_d = S_DECODE;
        else if (wd_expire) state_d = S_FAULT;
      end
      S_DECODE: begin
        is_bne_d = opcode[0];
        case (opcode)
          OPC_RTYPE: begin
            if (func inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT})
              state_d = S_R_EXEC;
            else if (func == FN_JR)
              state_d = S_JR;
            else
              state_d = S_ILLEGAL;
          end
          OPC_LW, OPC_SW:     state_d = S_MEM_ADDR;
          OPC_ADDI, OPC_SLTI: state_d = S_I_EXEC;
          OPC_BEQ, OPC_BNE:   state_d = S_BRANCH;
          OPC_J:              state_d = S_JUMP;
          OPC_JAL:            state_d = S_JAL;
          default:            state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OPC_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready)      state_d = S_MEM_WB;
        else if (wd_expire) state_d = S_FAULT;
      end
      S_MEM_WR: begin
        if (mem_ready)      state_d = S_FETCH;
        else if (wd_expire) state_d = S_FAULT;
      end
      S_R_EXEC: state_d = S_R_WB;
      S_I_EXEC: state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR, S_ILLEGAL:
        state_d = S_FETCH;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FETCH;
    endcase
  end

  // Outputs are forced low whenever rst is high, even mid-access.
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    IorD          = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = RD_RT;
    mem_to_reg    = WB_ALU;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    pc_src        = PCS_ALU;
    illegal       = 1'b0;
    bus_error     = 1'b0;
    alu_class     = ALU_ADD;
    op_en         = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_4;
          op_en     = 1'b1;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = SRCB_BR;
          op_en     = 1'b1;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          op_en     = 1'b1;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          IorD     = 1'b1;
        end
        S_MEM_WB: begin
          mem_to_reg = WB_MDR;
          reg_write  = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          IorD      = 1'b1;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_class = ALU_FUNC;
          op_en     = 1'b1;
        end
        S_R_WB: begin
          reg_dst   = RD_RD;
          reg_write = 1'b1;
          alu_class = ALU_FUNC;
          op_en     = 1'b1;
        end
        S_I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_class = (opcode == OPC_SLTI) ? ALU_SLT : ALU_ADD;
          op_en     = 1'b1;
        end
        S_I_WB: begin
          reg_write = 1'b1;
          alu_class = (opcode == OPC_SLTI) ? ALU_SLT : ALU_ADD;
          op_en     = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_class     = ALU_SUB;
          op_en         = 1'b1;
          pc_src        = PCS_ALUOUT;
          pc_write_cond = 1'b1;
        end
        S_JUMP: begin
          pc_src   = PCS_JUMP;
          pc_write = 1'b1;
        end
        S_JAL: begin
          reg_dst    = RD_RA;
          mem_to_reg = WB_PC;
          reg_write  = 1'b1;
          pc_src     = PCS_JUMP;
          pc_write   = 1'b1;
        end
        S_JR: begin
          pc_src   = PCS_REG;
          pc_write = 1'b1;
        end
        S_ILLEGAL: illegal   = 1'b1;
        S_FAULT:   bus_error = 1'b1;
        default: ;
      endcase
    end
  end

  mc_alu_decoder #(.OP_W(OP_W)) u_alu_dec (
    .alu_class (alu_class),
    .func      (func),
    .operation (dec_op)
  );

  assign operation = op_en ? dec_op : '0;
  assign pc_load   = pc_write | (pc_write_cond & (zero ^ is_bne_q));

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed and randomized instruction sequences checked cycle by cycle
// against a per-instruction expected output trace.
module tb_mc_control_fsm;

  localparam int OP_W = 3;
  localparam int WMAX = 4;

  logic clk, rst, zero, mem_ready;
  logic [5:0] opcode, func;
  logic mem_read, mem_write, IorD, ir_write, reg_write, alu_src_a;
  logic pc_load, illegal, bus_error;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
  logic [OP_W-1:0] operation;

  mc_control_fsm #(.OP_W(OP_W), .WAIT_MAX(WMAX)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
    .IorD(IorD), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .operation(operation), .pc_src(pc_src),
    .pc_load(pc_load), .illegal(illegal), .bus_error(bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [19:0] got;
  assign got = {mem_read, mem_write, IorD, ir_write, reg_dst, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, operation, pc_src,
                pc_load, illegal, bus_error};

  localparam logic [19:0] MR = 20'h80000, MW = 20'h40000, IORD = 20'h20000;
  localparam logic [19:0] IRW = 20'h10000, RW = 20'h00800, ASA = 20'h00400;
  localparam logic [19:0] PL = 20'h00004, ILL = 20'h00002, BE = 20'h00001;

  localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010;
  localparam logic [2:0] A_SUB = 3'b110, A_SLT = 3'b111;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
  localparam logic [5:0] SLTI = 6'b001010, JMP = 6'b000010, JAL = 6'b000011;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
  localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010, F_JR = 6'b001000;

  int vectors = 0;
  int miscompares = 0;
  int irw_cnt;
  bit faulted;
  logic [19:0] exp_q[$];
  bit rdy_q[$];
  logic [5:0] cur_op, cur_fn;
  logic cur_z;

  function automatic logic [19:0] f2(input logic [1:0] v, input int pos);
    return 20'(v) << pos;
  endfunction

  function automatic logic [19:0] f3(input logic [2:0] v);
    return 20'(v) << 5;
  endfunction

  function automatic bit rnd();
    return ($urandom_range(0, 1) != 0);
  endfunction

  task automatic push(input logic [19:0] v, input bit r);
    exp_q.push_back(v);
    rdy_q.push_back(r);
  endtask

  // Memory phase: w not-ready cycles, then completion; more than WMAX waits traps.
  task automatic mem_phase(input logic [19:0] vw, input logic [19:0] vd, input int w);
    for (int i = 0; i < w; i++) begin
      push(vw, 1'b0);
      if (i == WMAX) begin
        faulted = 1'b1;
        for (int k = 0; k < 3; k++) push(BE, rnd());
        return;
      end
    end
    push(vd, 1'b1);
  endtask

  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int wf, input int wm);
    logic [2:0] rop;
    logic taken;
    exp_q.delete();
    rdy_q.delete();
    faulted = 1'b0;
    cur_op = op; cur_fn = fn; cur_z = z;
    mem_phase(MR | f2(2'b01, 8) | f3(A_ADD),
              MR | IRW | PL | f2(2'b01, 8) | f3(A_ADD), wf);
    if (faulted) return;
    push(f2(2'b11, 8) | f3(A_ADD), rnd());
    case (op)
      LW, SW: begin
        push(ASA | f2(2'b10, 8) | f3(A_ADD), rnd());
        if (op == LW) begin
          mem_phase(MR | IORD, MR | IORD, wm);
          if (!faulted) push(RW | f2(2'b01, 12), rnd());
        end else begin
          mem_phase(MW | IORD, MW | IORD, wm);
        end
      end
      ADDI, SLTI: begin
        rop = (op == SLTI) ? A_SLT : A_ADD;
        push(ASA | f2(2'b10, 8) | f3(rop), rnd());
        push(RW | f3(rop), rnd());
      end
      BEQ, BNE: begin
        taken = (op == BEQ) ? z : !z;
        push(ASA | f3(A_SUB) | f2(2'b01, 3) | (taken ? PL : 20'h0), rnd());
      end
      JMP: push(f2(2'b10, 3) | PL, rnd());
      JAL: push(f2(2'b10, 14) | f2(2'b10, 12) | RW | f2(2'b10, 3) | PL, rnd());
      RT: begin
        case (fn)
          F_ADD: rop = A_ADD;
          F_SUB: rop = A_SUB;
          F_AND: rop = A_AND;
          F_OR:  rop = A_OR;
          F_SLT: rop = A_SLT;
          F_JR: begin
            push(f2(2'b11, 3) | PL, rnd());
            return;
          end
          default: begin
            push(ILL, rnd());
            return;
          end
        endcase
        push(ASA | f3(rop), rnd());
        push(f2(2'b01, 14) | RW | f3(rop), rnd());
      end
      default: push(ILL, rnd());
    endcase
  endtask

  task automatic check(input logic [19:0] exp, input string tag);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %05h expected %05h", tag, got, exp);
    end
  endtask

  task automatic drive(input string tag, input int stop_at);
    irw_cnt = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == stop_at) break;
      @(posedge clk); #1;
      rst = 1'b0;
      opcode = cur_op; func = cur_fn; zero = cur_z;
      mem_ready = rdy_q[i];
      @(negedge clk);
      if (ir_write === 1'b1) irw_cnt++;
      check(exp_q[i], $sformatf("%s[%0d]", tag, i));
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst = 1'b1;
      mem_ready = rnd();
      @(negedge clk);
      check(20'h0, "reset");
    end
  endtask

  logic [11:0] tbl [16];
  initial begin
    tbl = '{{RT, F_ADD}, {RT, F_SUB}, {RT, F_AND}, {RT, F_OR}, {RT, F_SLT},
            {RT, F_JR}, {RT, 6'b111111}, {LW, 6'h15}, {SW, 6'h2a},
            {BEQ, 6'h01}, {BNE, 6'h02}, {ADDI, 6'h03}, {SLTI, 6'h04},
            {JMP, 6'h05}, {JAL, 6'h06}, {6'b111111, 6'h00}};
  end

  initial begin
    rst = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = '0; func = '0;
    do_reset(3);

    build(RT, F_ADD, 1'b0, 0, 0);        drive("add", -1);
    build(LW, 6'h0, 1'b0, 3, 3);         drive("lw_wait", -1);
    vectors++;
    assert (irw_cnt === 1) else begin
      miscompares++;
      $error("FAIL lw_ir_write_pulses: observed %0d expected 1", irw_cnt);
    end
    build(BNE, 6'h0, 1'b0, 0, 0);        drive("bne_z0", -1);
    build(BNE, 6'h0, 1'b1, 0, 0);        drive("bne_z1", -1);
    build(BEQ, 6'h0, 1'b0, 0, 0);        drive("beq_z0", -1);
    build(BEQ, 6'h0, 1'b1, 0, 0);        drive("beq_z1", -1);
    build(JAL, 6'h0, 1'b0, 0, 0);        drive("jal", -1);
    build(JMP, 6'h0, 1'b0, 1, 0);        drive("j", -1);
    build(RT, F_JR, 1'b0, 0, 0);         drive("jr", -1);
    build(6'b111111, 6'h0, 1'b0, 0, 0);  drive("illegal_op", -1);
    build(RT, 6'b000001, 1'b0, 0, 0);    drive("illegal_fn", -1);
    build(SLTI, 6'h0, 1'b0, 0, 0);       drive("slti", -1);
    build(SW, 6'h0, 1'b0, 0, WMAX);      drive("sw_maxwait", -1);
    build(RT, F_SLT, 1'b0, WMAX, 0);     drive("slt_fetchmax", -1);

    build(LW, 6'h0, 1'b0, 0, 3);         drive("lw_rst", 4);
    do_reset(2);

    for (int n = 0; n < 40; n++) begin
      int k;
      k = int'($urandom_range(0, 15));
      build(tbl[k][11:6], tbl[k][5:0], rnd(),
            int'($urandom_range(0, WMAX)), int'($urandom_range(0, WMAX)));
      drive($sformatf("rnd%0d", n), -1);
    end

    build(SW, 6'h0, 1'b0, 0, WMAX + 1);  drive("sw_fault", -1);
    do_reset(1);
    build(RT, F_OR, 1'b1, 0, 0);         drive("after_fault", -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
